exe_mem_stage: RTL and testbench

EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

---
 rtl/arm_pkg.sv | 39 +++
 rtl/status_reg.sv | 18 +
 rtl/exe_mem_stage.sv | 155 +++++++++++++++
 tb/tb_exe_mem_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style pipeline: status-flag bit positions,
// EXE command codes and the EXE->MEM payload carried by the pipeline buffer.
package arm_pkg;

    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMD_CMP = 4'b0100;
    localparam logic [3:0] EXE_CMD_TST = 4'b0110;
    localparam logic [3:0] EXE_CMD_LDR = 4'b0010;
    localparam logic [3:0] EXE_CMD_STR = 4'b0010;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic [3:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] st_val;
    } exe_mem_payload_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/status_reg.sv
// 4-bit {Z,C,N,V} flag register; loads on an accepted flag-setting instruction.
module status_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'b0000;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline buffer: 2-entry in-order skid buffer with flush and flag register.
// Optional result forwarding from buffered entries is enabled by defining EXE_MEM_FWD_EN.
module exe_mem_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_valid,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic        exe_mem_w_en,
    input  logic        exe_s,
    input  logic [3:0]  exe_dest,
    input  logic [31:0] exe_alu_result,
    input  logic [31:0] exe_st_val,
    input  logic [3:0]  exe_sr,
    input  logic        flush,
    output logic        exe_ready,
    output logic        mem_valid,
    output logic        mem_wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [3:0]  mem_dest,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_st_val,
    input  logic        mem_ready,
`ifdef EXE_MEM_FWD_EN
    output logic        fwd_valid,
    output logic [3:0]  fwd_dest,
    output logic [31:0] fwd_data,
`endif
    output logic [3:0]  status,
    output logic        carry
);

    buf_state_t       state;
    buf_state_t       state_next;
    exe_mem_payload_t slots [2];
    exe_mem_payload_t offer;
    exe_mem_payload_t head;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             accept;
    logic             pop;

    assign exe_ready = (state != BUF_FULL);
    assign mem_valid = (state != BUF_EMPTY);
    assign accept    = exe_valid & exe_ready & ~flush;
    assign pop       = mem_valid & mem_ready;

    assign offer = '{wb_en:      exe_wb_en,
                     mem_r_en:   exe_mem_r_en,
                     mem_w_en:   exe_mem_w_en,
                     dest:       exe_dest,
                     alu_result: exe_alu_result,
                     st_val:     exe_st_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy: flush wins over everything; accept+pop together keep the level.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) state_next = BUF_ONE;
                BUF_ONE: begin
                    if (accept && !pop) begin
                        state_next = BUF_FULL;
                    end else if (pop && !accept) begin
                        state_next = BUF_EMPTY;
                    end
                end
                BUF_FULL:  if (pop) state_next = BUF_ONE;
                default:   state_next = BUF_EMPTY;
            endcase
        end
    end

    // Circular storage: with one entry, a simultaneous accept and pop moves
    // the read pointer onto the slot just written, making it the new head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            slots[0] <= '0;
            slots[1] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                slots[wr_ptr] <= offer;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign head           = mem_valid ? slots[rd_ptr] : '0;
    assign mem_wb_en      = head.wb_en;
    assign mem_r_en       = head.mem_r_en;
    assign mem_w_en       = head.mem_w_en;
    assign mem_dest       = head.dest;
    assign mem_alu_result = head.alu_result;
    assign mem_st_val     = head.st_val;

    status_reg u_status_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept & exe_s),
        .d     (exe_sr),
        .q     (status)
    );

    assign carry = status[SR_C];

`ifdef EXE_MEM_FWD_EN
    exe_mem_payload_t newest;
    exe_mem_payload_t oldest;
    logic             newest_ok;
    logic             oldest_ok;

    // The newest entry always sits just behind the write pointer.
    assign newest    = slots[~wr_ptr];
    assign oldest    = slots[rd_ptr];
    assign newest_ok = mem_valid && newest.wb_en && !newest.mem_r_en;
    assign oldest_ok = (state == BUF_FULL) && oldest.wb_en && !oldest.mem_r_en;

    always_comb begin
        fwd_valid = 1'b0;
        fwd_dest  = 4'h0;
        fwd_data  = 32'h0;
        if (newest_ok) begin
            fwd_valid = 1'b1;
            fwd_dest  = newest.dest;
            fwd_data  = newest.alu_result;
        end else if (oldest_ok) begin
            fwd_valid = 1'b1;
            fwd_dest  = oldest.dest;
            fwd_data  = oldest.alu_result;
        end
    end
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_exe_mem_stage;
    import arm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_valid;
    logic        exe_wb_en;
    logic        exe_mem_r_en;
    logic        exe_mem_w_en;
    logic        exe_s;
    logic [3:0]  exe_dest;
    logic [31:0] exe_alu_result;
    logic [31:0] exe_st_val;
    logic [3:0]  exe_sr;
    logic        flush;
    logic        exe_ready;
    logic        mem_valid;
    logic        mem_wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  mem_dest;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_st_val;
    logic        mem_ready;
    logic [3:0]  status;
    logic        carry;
`ifdef EXE_MEM_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_dest;
    logic [31:0] fwd_data;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    exe_mem_payload_t model_q[$];
    logic [3:0]       model_status;

    exe_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exe_valid      (exe_valid),
        .exe_wb_en      (exe_wb_en),
        .exe_mem_r_en   (exe_mem_r_en),
        .exe_mem_w_en   (exe_mem_w_en),
        .exe_s          (exe_s),
        .exe_dest       (exe_dest),
        .exe_alu_result (exe_alu_result),
        .exe_st_val     (exe_st_val),
        .exe_sr         (exe_sr),
        .flush          (flush),
        .exe_ready      (exe_ready),
        .mem_valid      (mem_valid),
        .mem_wb_en      (mem_wb_en),
        .mem_r_en       (mem_r_en),
        .mem_w_en       (mem_w_en),
        .mem_dest       (mem_dest),
        .mem_alu_result (mem_alu_result),
        .mem_st_val     (mem_st_val),
        .mem_ready      (mem_ready),
`ifdef EXE_MEM_FWD_EN
        .fwd_valid      (fwd_valid),
        .fwd_dest       (fwd_dest),
        .fwd_data       (fwd_data),
`endif
        .status         (status),
        .carry          (carry)
    );

    always #5 clk = ~clk;

    task automatic set_offer(input logic v, input logic wb, input logic r, input logic w,
                             input logic s, input logic [3:0] dest, input logic [31:0] res,
                             input logic [31:0] stv, input logic [3:0] sr);
        exe_valid      = v;
        exe_wb_en      = wb;
        exe_mem_r_en   = r;
        exe_mem_w_en   = w;
        exe_s          = s;
        exe_dest       = dest;
        exe_alu_result = res;
        exe_st_val     = stv;
        exe_sr         = sr;
    endtask

    // One clock: the model decides accept/pop from the pre-edge view, then
    // applies them at the edge; returns on the following falling edge.
    task automatic step_cycle();
        bit               acc;
        bit               pop;
        exe_mem_payload_t item;
        acc  = exe_valid && (model_q.size() < 2) && !flush;
        pop  = (model_q.size() > 0) && mem_ready;
        item = '{wb_en: exe_wb_en, mem_r_en: exe_mem_r_en, mem_w_en: exe_mem_w_en,
                 dest: exe_dest, alu_result: exe_alu_result, st_val: exe_st_val};
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(item);
        end
        if (acc && exe_s) model_status = exe_sr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        set_offer(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
        model_q.delete();
        model_status = 4'b0000;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || exe_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_handshake: mem_valid=%b exe_ready=%b required 0/1", mem_valid, exe_ready);
        end
        tests_run++;
        if (status !== 4'b0000 || carry !== 1'b0 || mem_alu_result !== 32'h0 || mem_dest !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: status=%b carry=%b result=%h dest=%h required all zero",
                     status, carry, mem_alu_result, mem_dest);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_offer();
        mem_ready = 1'b1;
        set_offer(1, 1, 0, 0, 0, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        step_cycle();
        set_offer(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if (mem_valid !== 1'b1 || mem_dest !== 4'h3 || mem_alu_result !== 32'h10 || mem_wb_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_offer: valid=%b dest=%h result=%h wb=%b required 1/3/00000010/1",
                     mem_valid, mem_dest, mem_alu_result, mem_wb_en);
        end
        tests_run++;
        if (status !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL single_status: status=%b required 0000", status);
        end
        step_cycle();
        tests_run++;
        if (mem_valid !== 1'b0 || mem_alu_result !== 32'h0 || mem_st_val !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL single_drain: valid=%b result=%h stval=%h required 0/0/0",
                     mem_valid, mem_alu_result, mem_st_val);
        end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b0;
        set_offer(1, 1, 0, 0, 0, 4'h1, 32'd1, 32'h0, 4'h0);
        step_cycle();
        tests_run++;
        if (exe_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready_one: exe_ready=%b required 1", exe_ready);
        end
        set_offer(1, 1, 0, 0, 0, 4'h2, 32'd2, 32'h0, 4'h0);
        step_cycle();
        tests_run++;
        if (exe_ready !== 1'b0 || mem_alu_result !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_full: exe_ready=%b head=%h required 0/1", exe_ready, mem_alu_result);
        end
        set_offer(1, 1, 0, 0, 0, 4'h3, 32'd3, 32'h0, 4'h0);
        step_cycle();
        tests_run++;
        if (exe_ready !== 1'b0 || mem_alu_result !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_stall: exe_ready=%b head=%h required 0/1", exe_ready, mem_alu_result);
        end
        mem_ready = 1'b1;
        step_cycle();
        tests_run++;
        if (exe_ready !== 1'b1 || mem_alu_result !== 32'd2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drain1: exe_ready=%b head=%h required 1/2", exe_ready, mem_alu_result);
        end
        step_cycle();
        set_offer(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if (mem_valid !== 1'b1 || mem_alu_result !== 32'd3 || mem_dest !== 4'h3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_third: valid=%b head=%h dest=%h required 1/3/3",
                     mem_valid, mem_alu_result, mem_dest);
        end
        step_cycle();
        tests_run++;
        if (mem_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_empty: mem_valid=%b required 0", mem_valid);
        end
    endtask

    task automatic test_status();
        mem_ready = 1'b0;
        set_offer(1, 0, 0, 0, 1, 4'h0, 32'h0, 32'h0, 4'b0100);
        step_cycle();
        tests_run++;
        if (status !== 4'b0100 || carry !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL status_load: status=%b carry=%b required 0100/1", status, carry);
        end
        set_offer(1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b1000);
        step_cycle();
        tests_run++;
        if (status !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL status_hold_s0: status=%b required 0100", status);
        end
        set_offer(1, 0, 0, 0, 1, 4'h0, 32'h0, 32'h0, 4'b0001);
        step_cycle();
        tests_run++;
        if (status !== 4'b0100 || exe_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL status_hold_full: status=%b exe_ready=%b required 0100/0", status, exe_ready);
        end
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        flush     = 1'b1;
        set_offer(1, 1, 0, 0, 1, 4'h7, 32'h77, 32'h0, 4'b1111);
        step_cycle();
        flush = 1'b0;
        set_offer(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if (mem_valid !== 1'b0 || exe_ready !== 1'b1 || mem_alu_result !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL flush_empty: valid=%b ready=%b result=%h required 0/1/0",
                     mem_valid, exe_ready, mem_alu_result);
        end
        tests_run++;
        if (status !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL flush_status: status=%b required 0100", status);
        end
    endtask

    task automatic test_one_simultaneous();
        mem_ready = 1'b0;
        set_offer(1, 1, 0, 0, 0, 4'h5, 32'h5, 32'h0, 4'h0);
        step_cycle();
        mem_ready = 1'b1;
        set_offer(1, 1, 0, 0, 0, 4'hA, 32'hA, 32'h0, 4'h0);
        step_cycle();
        set_offer(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if (mem_valid !== 1'b1 || exe_ready !== 1'b1 || mem_alu_result !== 32'hA) begin
            tests_failed++;
            $display("[TB] FAIL one_swap: valid=%b ready=%b head=%h required 1/1/0000000a",
                     mem_valid, exe_ready, mem_alu_result);
        end
        step_cycle();
        tests_run++;
        if (mem_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL one_swap_drain: mem_valid=%b required 0", mem_valid);
        end
    endtask

    task automatic test_async_reset();
        mem_ready = 1'b0;
        set_offer(1, 1, 0, 1, 1, 4'hC, 32'hC0FF_EE00, 32'h1234_5678, 4'b0011);
        step_cycle();
        step_cycle();
        set_offer(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if (exe_ready !== 1'b0 || status !== 4'b0011) begin
            tests_failed++;
            $display("[TB] FAIL areset_setup: ready=%b status=%b required 0/0011", exe_ready, status);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0 || exe_ready !== 1'b1 || status !== 4'b0000 || carry !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL areset_ctrl: valid=%b ready=%b status=%b carry=%b required 0/1/0000/0",
                     mem_valid, exe_ready, status, carry);
        end
        tests_run++;
        if ({mem_wb_en, mem_r_en, mem_w_en, mem_dest, mem_alu_result, mem_st_val} !== 71'h0) begin
            tests_failed++;
            $display("[TB] FAIL areset_payload: dest=%h result=%h stval=%h required zero",
                     mem_dest, mem_alu_result, mem_st_val);
        end
        model_q.delete();
        model_status = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        exe_mem_payload_t exp_head;
        logic [70:0]      act_head;
        for (int i = 0; i < 400; i++) begin
            mem_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 15) == 0);
            set_offer(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 4'($urandom), $urandom, $urandom, 4'($urandom));
            step_cycle();
            exp_head = (model_q.size() > 0) ? model_q[0] : '0;
            act_head = {mem_wb_en, mem_r_en, mem_w_en, mem_dest, mem_alu_result, mem_st_val};
            tests_run++;
            if (mem_valid !== (model_q.size() > 0) || exe_ready !== (model_q.size() < 2)) begin
                tests_failed++;
                $display("[TB] FAIL rand_ctrl[%0d]: valid=%b ready=%b required occupancy %0d",
                         i, mem_valid, exe_ready, model_q.size());
            end
            tests_run++;
            if (act_head !== exp_head) begin
                tests_failed++;
                $display("[TB] FAIL rand_head[%0d]: got %h required %h", i, act_head, exp_head);
            end
            tests_run++;
            if (status !== model_status || carry !== model_status[SR_C]) begin
                tests_failed++;
                $display("[TB] FAIL rand_status[%0d]: status=%b carry=%b required %b",
                         i, status, carry, model_status);
            end
`ifdef EXE_MEM_FWD_EN
            begin
                bit          f_ok = 1'b0;
                logic [3:0]  f_dest = 4'h0;
                logic [31:0] f_data = 32'h0;
                for (int k = model_q.size() - 1; k >= 0; k--) begin
                    if (!f_ok && model_q[k].wb_en && !model_q[k].mem_r_en) begin
                        f_ok   = 1'b1;
                        f_dest = model_q[k].dest;
                        f_data = model_q[k].alu_result;
                    end
                end
                tests_run++;
                if (fwd_valid !== f_ok || (f_ok && (fwd_dest !== f_dest || fwd_data !== f_data))) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_fwd[%0d]: got %b/%h/%h required %b/%h/%h",
                             i, fwd_valid, fwd_dest, fwd_data, f_ok, f_dest, f_data);
                end
            end
`endif
        end
        flush = 1'b0;
        set_offer(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_single_offer();
        test_back_to_back();
        test_status();
        test_flush();
        test_one_simultaneous();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
